dcache_ctrl: RTL and testbench
==============================

DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock, all state updating on its rising edge.
REQ-002 The block SHALL have port proc_reset, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have port proc_read, input, 1 bit: CPU word read request.
REQ-004 The block SHALL have port proc_write, input, 1 bit: CPU word write request.
REQ-005 The block SHALL have port proc_addr, input, 30 bits: CPU word address (tag [29:5], index [4:2], offset [1:0]).
REQ-006 The block SHALL have port proc_wdata, input, 32 bits: CPU write data.
REQ-007 The block SHALL have port proc_stall, output, 1 bit: CPU must hold its request and pipeline.
REQ-008 The block SHALL have port proc_rdata, output, 32 bits: CPU read data.
REQ-009 The block SHALL have port mem_read, output, 1 bit: memory block read strobe.
REQ-010 The block SHALL have port mem_write, output, 1 bit: memory block write strobe.
REQ-011 The block SHALL have port mem_addr, output, 28 bits: memory block address {tag,index}.
REQ-012 The block SHALL have port mem_wdata, output, 128 bits: write-back block, word 0 in [31:0].
REQ-013 The block SHALL have port mem_rdata, input, 128 bits: fill block, word 0 in [31:0].
REQ-014 The block SHALL have port mem_ready, input, 1 bit: one-cycle completion pulse for the current memory access.

Function
REQ-015 The block SHALL be a direct-mapped, write-back, write-allocate cache: 8 lines, each with a valid bit, a dirty bit, a 25-bit tag and a 128-bit data field.
REQ-016 The FSM SHALL have exactly three states, IDLE, WRITEBACK and ALLOCATE.
REQ-017 Hit condition: state IDLE, request asserted, indexed line valid and tag equal.
REQ-018 Read hit: proc_rdata SHALL return the offset word combinationally in the same cycle, with proc_stall=0 (zero extra latency).
REQ-019 Write hit: the offset word SHALL be replaced by proc_wdata and dirty set to 1 at the next edge, with proc_stall=0.
REQ-020 proc_stall SHALL equal (proc_read|proc_write) & ~hit; proc_rdata SHALL be 0 whenever not a read hit.
REQ-021 Miss on a clean or invalid line: IDLE->ALLOCATE.
REQ-022 Miss on a valid dirty line: IDLE->WRITEBACK.
REQ-023 WRITEBACK: mem_write=1, mem_addr={stored tag,index}, mem_wdata=line data, all held until mem_ready; on mem_ready ->ALLOCATE.
REQ-024 ALLOCATE: mem_read=1, mem_addr={proc_addr tag,index}, held until mem_ready.
REQ-025 On mem_ready in ALLOCATE, the line SHALL load mem_rdata with valid=1, dirty=0 and the new tag, and the FSM SHALL go to IDLE.
REQ-026 After a fill, the next cycle SHALL be a hit that serves the request, so a clean miss costs fill latency + 1 cycle.
REQ-027 mem_read and mem_write SHALL be decoded from state only and SHALL never be high together.
REQ-028 mem_ready SHALL be ignored in IDLE.
REQ-029 proc_read and proc_write asserted together SHALL be treated as a write.
REQ-030 Requests held during WRITEBACK or ALLOCATE SHALL be stalled and not sampled; the CPU holds proc_addr stable.

Reset
REQ-031 On proc_reset high at a clock edge, state SHALL become IDLE and all valid and dirty bits SHALL clear; tags and data are not reset.
REQ-032 During reset: proc_stall=0, proc_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
REQ-033 Reset during WRITEBACK or ALLOCATE SHALL abandon the access; the memory strobes drop in the cycle after the reset edge.

Configuration
REQ-034 With macro DCACHE_PERF_CNT_EN defined, the block SHALL add outputs hit_cnt[15:0] and miss_cnt[15:0].
REQ-035 hit_cnt SHALL increment once per hit cycle; miss_cnt SHALL increment once per IDLE->WRITEBACK or IDLE->ALLOCATE transition.
REQ-036 Both counters SHALL wrap at 16'hFFFF->0 and clear on reset.
REQ-037 Without DCACHE_PERF_CNT_EN, the counter ports and logic SHALL be absent, with identical behaviour otherwise.

Verification
REQ-038 Cold read: read addr 0x00000001 after reset -> stall; mem_read with mem_addr=0x0000000; mem_ready with mem_rdata words {D,C,B,A} -> next cycle proc_rdata=B, stall=0.
REQ-039 Write hit: write 0x12345678 to 0x00000001 after the fill -> no stall; subsequent read returns 0x12345678.
REQ-040 Dirty eviction: read 0x00000021 (same index 0, tag 1) -> mem_write with mem_addr=0x0000000 and mem_wdata[63:32]=0x12345678, then mem_read with mem_addr=0x0000008.
REQ-041 Mid-fill reset: proc_reset pulsed in ALLOCATE -> next cycle mem_read=0; read 0x00000001 -> misses again.
REQ-042 Read+write on a hit -> write performed and line marked dirty.
REQ-043 DCACHE_PERF_CNT_EN: sequence miss, hit, hit -> miss_cnt=1, hit_cnt=3, counting the post-fill hit cycle.

Source files
------------

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller: 8 lines of 4 words.
// Defining DCACHE_PERF_CNT_EN adds the hit_cnt/miss_cnt performance counter outputs.
module dcache_ctrl (
  input  logic         clk,
  input  logic         proc_reset,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic         proc_stall,
  output logic [31:0]  proc_rdata,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [15:0]  hit_cnt,
  output logic [15:0]  miss_cnt
`endif
);

  localparam int unsigned Lines = 8;

  typedef enum logic [1:0] {StIdle, StWriteback, StAllocate} state_e;

  state_e state_q, state_d;

  logic [Lines-1:0] valid_q;
  logic [Lines-1:0] dirty_q;
  logic [24:0]      tag_q  [Lines];
  logic [127:0]     data_q [Lines];

  logic [2:0]  idx;
  logic [24:0] tag;
  logic [1:0]  off;
  logic        req;
  logic        hit;
  logic        miss_start;
  logic        wr_hit;
  logic        fill;

  assign idx = proc_addr[4:2];
  assign tag = proc_addr[29:5];
  assign off = proc_addr[1:0];
  assign req = proc_read | proc_write;

  always_comb begin
    hit        = 1'b0;
    miss_start = 1'b0;
    if (state_q == StIdle && req && !proc_reset) begin
      hit        = valid_q[idx] && (tag_q[idx] == tag);
      miss_start = !hit;
    end
  end

  // A simultaneous read+write is a write, so proc_write alone decides the hit kind.
  assign wr_hit = hit & proc_write;
  assign fill   = (state_q == StAllocate) & mem_ready;

  always_comb begin
    state_d    = state_q;
    proc_stall = 1'b0;
    proc_rdata = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (!proc_reset) begin
      proc_stall = req & ~hit;
      if (hit && !proc_write) begin
        proc_rdata = data_q[idx][{off, 5'd0} +: 32];
      end
      unique case (state_q)
        StIdle: begin
          if (miss_start) begin
            state_d = (valid_q[idx] && dirty_q[idx]) ? StWriteback : StAllocate;
          end
        end
        StWriteback: begin
          mem_write = 1'b1;
          mem_addr  = {tag_q[idx], idx};
          mem_wdata = data_q[idx];
          if (mem_ready) state_d = StAllocate;
        end
        StAllocate: begin
          mem_read = 1'b1;
          mem_addr = {tag, idx};
          if (mem_ready) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Tags and data are deliberately left unreset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q <= StIdle;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (wr_hit) begin
        data_q[idx][{off, 5'd0} +: 32] <= proc_wdata;
        dirty_q[idx]                   <= 1'b1;
      end
      if (fill) begin
        data_q[idx]  <= mem_rdata;
        tag_q[idx]   <= tag;
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  logic [15:0] hit_cnt_q;
  logic [15:0] miss_cnt_q;

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit)        hit_cnt_q  <= hit_cnt_q + 16'd1;
      if (miss_start) miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: a line-array cache model plus an expected-memory-transaction
// queue is compared against the DUT every cycle, alongside directed literal checks.
module tb_dcache_ctrl;

  logic         clk;
  logic         proc_reset;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
`ifdef DCACHE_PERF_CNT_EN
  logic [15:0]  hit_cnt;
  logic [15:0]  miss_cnt;
`endif

  dcache_ctrl u_dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_stall (proc_stall),
    .proc_rdata (proc_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
`ifdef DCACHE_PERF_CNT_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Backing memory: explicit blocks, otherwise a pattern derived from the block address.
  logic [127:0] mem_img [logic [27:0]];

  function automatic logic [127:0] img(input logic [27:0] a);
    logic [127:0] b;
    if (mem_img.exists(a)) return mem_img[a];
    for (int w = 0; w < 4; w++) begin
      logic [1:0] ws;
      ws = w[1:0];
      b[w*32 +: 32] = {a, ws, 2'b01};
    end
    return b;
  endfunction

  typedef struct {
    bit           wr;
    logic [27:0]  addr;
    logic [127:0] data;
  } op_t;

  op_t          exp_q [$];
  bit           m_valid [8];
  bit           m_dirty [8];
  logic [24:0]  m_tag   [8];
  logic [127:0] m_data  [8];
  int           m_hits   = 0;
  int           m_misses = 0;

  // Model and per-cycle comparison; inputs are stable here and take effect at the next edge.
  always @(negedge clk) begin
    logic        req;
    logic        mhit;
    logic [2:0]  idx;
    logic [24:0] tg;
    logic [1:0]  off;
    logic [31:0] exp_rd;
    op_t         op;
    req  = proc_read | proc_write;
    idx  = proc_addr[4:2];
    tg   = proc_addr[29:5];
    off  = proc_addr[1:0];
`ifdef DCACHE_PERF_CNT_EN
    check("hit_cnt", hit_cnt, m_hits[15:0]);
    check("miss_cnt", miss_cnt, m_misses[15:0]);
`endif
    if (proc_reset) begin
      check("rst_stall", proc_stall, 0);
      check("rst_rdata", proc_rdata, 0);
      check("rst_mrd", mem_read, 0);
      check("rst_mwr", mem_write, 0);
      check("rst_maddr", mem_addr, 0);
      check("rst_mwdata", mem_wdata, 0);
      for (int i = 0; i < 8; i++) begin
        m_valid[i] = 0;
        m_dirty[i] = 0;
      end
      exp_q.delete();
      m_hits   = 0;
      m_misses = 0;
    end else if (exp_q.size() != 0) begin
      op = exp_q[0];
      check("busy_stall", proc_stall, req);
      check("busy_rdata", proc_rdata, 0);
      check("busy_mrd", mem_read, !op.wr);
      check("busy_mwr", mem_write, op.wr);
      check("busy_maddr", mem_addr, op.addr);
      check("busy_mwdata", mem_wdata, op.wr ? op.data : 128'h0);
      if (mem_ready) begin
        if (op.wr) begin
          mem_img[op.addr] = op.data;
        end else begin
          m_valid[op.addr[2:0]] = 1;
          m_dirty[op.addr[2:0]] = 0;
          m_tag[op.addr[2:0]]   = op.addr[27:3];
          m_data[op.addr[2:0]]  = img(op.addr);
        end
        void'(exp_q.pop_front());
      end
    end else begin
      mhit   = req && m_valid[idx] && (m_tag[idx] == tg);
      exp_rd = (mhit && !proc_write) ? m_data[idx][off*32 +: 32] : 32'h0;
      check("stall", proc_stall, req && !mhit);
      check("rdata", proc_rdata, exp_rd);
      check("idle_mrd", mem_read, 0);
      check("idle_mwr", mem_write, 0);
      check("idle_maddr", mem_addr, 0);
      check("idle_mwdata", mem_wdata, 0);
      if (mhit) begin
        m_hits++;
        if (proc_write) begin
          m_data[idx][off*32 +: 32] = proc_wdata;
          m_dirty[idx] = 1;
        end
      end else if (req) begin
        m_misses++;
        if (m_valid[idx] && m_dirty[idx]) begin
          op.wr = 1; op.addr = {m_tag[idx], idx}; op.data = m_data[idx];
          exp_q.push_back(op);
        end
        op.wr = 0; op.addr = {tg, idx}; op.data = '0;
        exp_q.push_back(op);
      end
    end
  end

  // Memory responder: answers a held strobe after a few cycles with a one-cycle mem_ready.
  bit resp_en = 1;
  initial begin
    int cnt;
    cnt = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!resp_en) begin
        cnt = 0;
      end else if (mem_ready) begin
        mem_ready = 1'b0;
        cnt = 0;
      end else if (mem_read || mem_write) begin
        if (cnt == 2) begin
          mem_ready = 1'b1;
          mem_rdata = img(mem_addr);
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic wait_until(input int sel, input string name);
    bit ok;
    ok = 0;
    for (int n = 0; n < 64 && !ok; n++) begin
      @(negedge clk);
      case (sel)
        0:       ok = mem_read;
        1:       ok = mem_write;
        default: ok = !proc_stall;
      endcase
    end
    if (!ok) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic start_req(input logic rd, input logic wr, input logic [29:0] a,
                           input logic [31:0] d);
    @(posedge clk);
    #1;
    proc_read  = rd;
    proc_write = wr;
    proc_addr  = a;
    proc_wdata = d;
  endtask

  task automatic end_req();
    @(posedge clk);
    #1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
  endtask

  task automatic do_req(input logic rd, input logic wr, input logic [29:0] a,
                        input logic [31:0] d, input string name, output logic [31:0] rdat);
    start_req(rd, wr, a, d);
    wait_until(2, name);
    rdat = proc_rdata;
    end_req();
  endtask

  initial begin
    logic [31:0] rd;
    logic [29:0] a;
    logic [31:0] d;
    proc_reset = 1'b1;
    proc_read  = 1'b1;
    proc_write = 1'b0;
    proc_addr  = 30'h1;
    proc_wdata = '0;
    mem_img[28'h0] = {32'hDDDD3333, 32'hCCCC2222, 32'hBBBB1111, 32'hAAAA0000};
    repeat (2) @(posedge clk);
    #1;
    proc_reset = 1'b0;
    proc_read  = 1'b0;

    // Cold read of word 1 in block 0.
    start_req(1, 0, 30'h1, 0);
    @(negedge clk);
    check("cold_stall", proc_stall, 1);
    wait_until(0, "cold_mrd");
    check("cold_maddr", mem_addr, 28'h0);
    wait_until(2, "cold_done");
    check("cold_rdata", proc_rdata, 32'hBBBB1111);
    end_req();

    // Write hit then read back.
    start_req(0, 1, 30'h1, 32'h12345678);
    @(negedge clk);
    check("whit_stall", proc_stall, 0);
    end_req();
    do_req(1, 0, 30'h1, 0, "rd_back", rd);
    check("rd_back", rd, 32'h12345678);
`ifdef DCACHE_PERF_CNT_EN
    @(negedge clk);
    check("perf_miss", miss_cnt, 16'd1);
    check("perf_hit", hit_cnt, 16'd3);
`endif

    // Dirty eviction: same index, tag 1.
    start_req(1, 0, 30'h21, 0);
    wait_until(1, "evict_mwr");
    check("evict_waddr", mem_addr, 28'h0);
    check("evict_wword", mem_wdata[63:32], 32'h12345678);
    wait_until(0, "evict_mrd");
    check("evict_raddr", mem_addr, 28'h8);
    wait_until(2, "evict_done");
    check("evict_rdata", proc_rdata, 32'h00000085);
    end_req();

    // mem_ready pulsed while idle must be ignored.
    resp_en = 0;
    @(posedge clk);
    #1;
    mem_ready = 1'b1;
    @(negedge clk);
    check("idle_rdy_mrd", mem_read, 0);
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    @(negedge clk);
    check("idle_rdy_mwr", mem_write, 0);
    resp_en = 1;

    // Re-fetch block 0: must carry the written-back word.
    do_req(1, 0, 30'h1, 0, "refetch", rd);
    check("refetch", rd, 32'h12345678);

    // Read+write together on a hit acts as a write.
    do_req(1, 1, 30'h1, 32'hCAFEF00D, "rw_hit", rd);
    check("rw_hit_rdata", rd, 32'h0);
    start_req(1, 0, 30'h21, 0);
    wait_until(1, "rw_evict");
    check("rw_evict_word", mem_wdata[63:32], 32'hCAFEF00D);
    wait_until(2, "rw_evict_done");
    end_req();

    // Reset in the middle of a fill.
    resp_en = 0;
    start_req(1, 0, 30'h40, 0);
    wait_until(0, "midfill_mrd");
    @(posedge clk);
    #1;
    proc_reset = 1'b1;
    @(posedge clk);
    #1;
    proc_reset = 1'b0;
    @(negedge clk);
    check("midfill_mrd_drop", mem_read, 0);
    check("midfill_restall", proc_stall, 1);
    resp_en = 1;
    wait_until(2, "midfill_done");
    end_req();
    start_req(1, 0, 30'h1, 0);
    @(negedge clk);
    check("post_rst_miss", proc_stall, 1);
    wait_until(2, "post_rst_done");
    end_req();

    // Every index and offset: write-allocate then read back.
    for (int i = 0; i < 8; i++) begin
      a = {25'd5, i[2:0], i[1:0]};
      d = 32'h5A000000 | i;
      do_req(0, 1, a, d, "sweep_wr", rd);
      do_req(1, 0, a, 0, "sweep_rd", rd);
      check("sweep_rd", rd, d);
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
